// File: rtl/riscv_mc_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I control FSM: opcodes, immediate
// select codes, datapath mux codes and state encodings.
package riscv_mc_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] SRC_IMM_I = 3'd0;
  localparam logic [2:0] SRC_IMM_S = 3'd1;
  localparam logic [2:0] SRC_IMM_B = 3'd2;
  localparam logic [2:0] SRC_IMM_U = 3'd3;
  localparam logic [2:0] SRC_IMM_J = 3'd4;

  localparam logic [1:0] ALU_SRC_A_PC    = 2'd0;
  localparam logic [1:0] ALU_SRC_A_OLDPC = 2'd1;
  localparam logic [1:0] ALU_SRC_A_RS1   = 2'd2;

  localparam logic [1:0] ALU_SRC_B_RS2  = 2'd0;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'd1;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'd2;

  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_CMP   = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

  localparam logic [1:0] RESULT_ALU = 2'd0;
  localparam logic [1:0] RESULT_MEM = 2'd1;
  localparam logic [1:0] RESULT_PC4 = 2'd2;
  localparam logic [1:0] RESULT_IMM = 2'd3;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_MEMADR = 4'd3;
  localparam logic [3:0] ST_MEMRD  = 4'd4;
  localparam logic [3:0] ST_MEMWB  = 4'd5;
  localparam logic [3:0] ST_MEMWR  = 4'd6;
  localparam logic [3:0] ST_EXEC_R = 4'd7;
  localparam logic [3:0] ST_EXEC_I = 4'd8;
  localparam logic [3:0] ST_EXEC_U = 4'd9;
  localparam logic [3:0] ST_ALUWB  = 4'd10;
  localparam logic [3:0] ST_BRANCH = 4'd11;
  localparam logic [3:0] ST_JAL    = 4'd12;
  localparam logic [3:0] ST_JALR   = 4'd13;
  localparam logic [3:0] ST_TRAP   = 4'd14;

  // Immediate format implied by the opcode; unknown opcodes fall back to I.
  function automatic logic [2:0] imm_src_for(input logic [6:0] opcode);
    case (opcode)
      OPC_STORE:           return SRC_IMM_S;
      OPC_BRANCH:          return SRC_IMM_B;
      OPC_LUI, OPC_AUIPC:  return SRC_IMM_U;
      OPC_JAL:             return SRC_IMM_J;
      default:             return SRC_IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I main control FSM with memory-wait timeout.
// Optional feature macro RISCV_CTRL_ILLEGAL_TRAP_EN: unknown opcodes enter a sticky TRAP state and drive o_illegal.
module riscv_mc_ctrl
  import riscv_mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_opcode,
  input  logic       i_mem_ready,
  input  logic       i_br_taken,
  output logic [2:0] o_imm_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_result_src,
  output logic       o_mem_re,
  output logic       o_mem_we,
  output logic       o_addr_src,
  output logic       o_ir_we,
  output logic       o_pc_we,
  output logic       o_rf_we,
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
  output logic       o_illegal,
`endif
  output logic       o_mem_timeout
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [3:0]       state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             mem_state;
  logic             timeout_hit;

  assign mem_state   = (state_reg == ST_FETCH) || (state_reg == ST_MEMRD) || (state_reg == ST_MEMWR);
  // The abort fires on the MEM_TIMEOUT-th consecutive not-ready cycle itself.
  assign timeout_hit = mem_state && !i_mem_ready && (wait_cnt_reg == CNT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   state_next = ST_FETCH;
      ST_FETCH: begin
        if (timeout_hit)      state_next = ST_FETCH;
        else if (i_mem_ready) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        case (i_opcode)
          OPC_LOAD, OPC_STORE: state_next = ST_MEMADR;
          OPC_OP:              state_next = ST_EXEC_R;
          OPC_OP_IMM:          state_next = ST_EXEC_I;
          OPC_LUI, OPC_AUIPC:  state_next = ST_EXEC_U;
          OPC_BRANCH:          state_next = ST_BRANCH;
          OPC_JAL:             state_next = ST_JAL;
          OPC_JALR:            state_next = ST_JALR;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
          default:             state_next = ST_TRAP;
`else
          default:             state_next = ST_FETCH;
`endif
        endcase
      end
      ST_MEMADR: state_next = (i_opcode == OPC_STORE) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD: begin
        if (timeout_hit)      state_next = ST_FETCH;
        else if (i_mem_ready) state_next = ST_MEMWB;
      end
      ST_MEMWR: begin
        if (timeout_hit || i_mem_ready) state_next = ST_FETCH;
      end
      ST_EXEC_R, ST_EXEC_I, ST_EXEC_U: state_next = ST_ALUWB;
      ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_JAL, ST_JALR: state_next = ST_FETCH;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
      ST_TRAP:   state_next = ST_TRAP;
`endif
      default:   state_next = ST_IDLE;
    endcase
  end

  // A timeout re-enters FETCH without changing state, so it must clear the count too.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if ((state_next != state_reg) || timeout_hit)
      wait_cnt_next = '0;
    else if (mem_state && !i_mem_ready)
      wait_cnt_next = wait_cnt_reg + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    o_imm_src    = SRC_IMM_I;
    o_alu_src_a  = ALU_SRC_A_PC;
    o_alu_src_b  = ALU_SRC_B_RS2;
    o_alu_op     = ALU_OP_ADD;
    o_result_src = RESULT_ALU;
    o_mem_re     = 1'b0;
    o_mem_we     = 1'b0;
    o_addr_src   = 1'b0;
    o_ir_we      = 1'b0;
    o_pc_we      = 1'b0;
    o_rf_we      = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        o_mem_re    = 1'b1;
        o_alu_src_b = ALU_SRC_B_FOUR;
        o_ir_we     = i_mem_ready;
        o_pc_we     = i_mem_ready;
      end
      ST_DECODE: begin
        o_imm_src   = imm_src_for(i_opcode);
        o_alu_src_a = ALU_SRC_A_OLDPC;
        o_alu_src_b = ALU_SRC_B_IMM;
      end
      ST_MEMADR: begin
        o_imm_src   = (i_opcode == OPC_STORE) ? SRC_IMM_S : SRC_IMM_I;
        o_alu_src_a = ALU_SRC_A_RS1;
        o_alu_src_b = ALU_SRC_B_IMM;
      end
      ST_MEMRD: begin
        o_mem_re   = 1'b1;
        o_addr_src = 1'b1;
      end
      ST_MEMWB: begin
        o_rf_we      = 1'b1;
        o_result_src = RESULT_MEM;
      end
      ST_MEMWR: begin
        o_mem_we   = 1'b1;
        o_addr_src = 1'b1;
      end
      ST_EXEC_R: begin
        o_alu_src_a = ALU_SRC_A_RS1;
        o_alu_src_b = ALU_SRC_B_RS2;
        o_alu_op    = ALU_OP_FUNCT;
      end
      ST_EXEC_I: begin
        o_alu_src_a = ALU_SRC_A_RS1;
        o_alu_src_b = ALU_SRC_B_IMM;
        o_alu_op    = ALU_OP_FUNCT;
      end
      ST_EXEC_U: begin
        o_imm_src = SRC_IMM_U;
        if (i_opcode == OPC_AUIPC) begin
          o_alu_src_a = ALU_SRC_A_OLDPC;
          o_alu_src_b = ALU_SRC_B_IMM;
        end
      end
      ST_ALUWB: begin
        o_rf_we = 1'b1;
        // LUI writes the immediate straight through, so the decoder must keep emitting U.
        if (i_opcode == OPC_LUI) begin
          o_result_src = RESULT_IMM;
          o_imm_src    = SRC_IMM_U;
        end
      end
      ST_BRANCH: begin
        o_imm_src   = SRC_IMM_B;
        o_alu_src_a = ALU_SRC_A_RS1;
        o_alu_src_b = ALU_SRC_B_RS2;
        o_alu_op    = ALU_OP_CMP;
        o_pc_we     = i_br_taken;
      end
      ST_JAL: begin
        o_imm_src    = SRC_IMM_J;
        o_rf_we      = 1'b1;
        o_result_src = RESULT_PC4;
        o_pc_we      = 1'b1;
      end
      ST_JALR: begin
        o_alu_src_a  = ALU_SRC_A_RS1;
        o_alu_src_b  = ALU_SRC_B_IMM;
        o_rf_we      = 1'b1;
        o_result_src = RESULT_PC4;
        o_pc_we      = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_mem_timeout = timeout_hit;

`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
  assign o_illegal = (state_reg == ST_TRAP);
`endif

endmodule
